// File: rtl/pixel_burst_writer.sv
// Pulls 24-bit pixels from a pull-style source into a burst buffer and writes
// each full buffer to the memory bus as a fixed-length burst of 32-bit words.
module pixel_burst_writer #(
    parameter int unsigned         ROW       = 1024,
    parameter int unsigned         COL       = 1280,
    parameter int unsigned         BURST_LEN = 64,
    parameter int unsigned         ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]   BASE_ADDR = '0
) (
    input  logic              clkin,
    input  logic              rst_n,
    input  logic              en,
    input  logic [23:0]       din,
    output logic              din_rd,
    input  logic              value,
    output logic              m_req,
    output logic [ADDR_W-1:0] m_addr,
    output logic [7:0]        m_len,
    input  logic              m_gnt,
    output logic [31:0]       m_data,
    output logic              m_dvalid,
    input  logic              m_dready,
    output logic              m_last,
    output logic              frame_done
);

    localparam int unsigned       IDX_W     = $clog2(BURST_LEN);
    localparam int unsigned       FRAME_PIX = ROW * COL;
    localparam int unsigned       PIX_W     = $clog2(FRAME_PIX + 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(BURST_LEN - 1);
    localparam logic [PIX_W-1:0]  PIX_STEP  = PIX_W'(BURST_LEN);
    localparam logic [PIX_W-1:0]  PIX_FRAME = PIX_W'(FRAME_PIX);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BURST_LEN * 4);

    typedef enum logic [1:0] {IDLE, FILL, REQ, SEND} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [23:0]        r_buf [BURST_LEN];
    logic [IDX_W-1:0]   r_wr_idx;
    logic [IDX_W-1:0]   r_rd_idx;
    logic [PIX_W-1:0]   r_pix_cnt;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_frame_done;

    logic               w_accept;
    logic               w_beat;
    logic               w_fill_done;
    logic               w_last_beat;
    logic [PIX_W-1:0]   w_pix_sum;

    assign w_accept    = (r_state == FILL) && value;
    assign w_beat      = (r_state == SEND) && m_dready;
    assign w_fill_done = w_accept && (r_wr_idx == IDX_LAST);
    assign w_last_beat = w_beat && (r_rd_idx == IDX_LAST);
    assign w_pix_sum   = r_pix_cnt + PIX_STEP;

    always_ff @(posedge clkin) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (en)          w_next = FILL;
            FILL: if (w_fill_done) w_next = REQ;
            REQ:  if (m_gnt)       w_next = SEND;
            SEND: if (w_last_beat) w_next = en ? FILL : IDLE;
            default:               w_next = IDLE;
        endcase
    end

    always_comb begin
        din_rd   = 1'b0;
        m_req    = 1'b0;
        m_dvalid = 1'b0;
        m_last   = 1'b0;
        m_data   = '0;
        case (r_state)
            FILL: din_rd = 1'b1;
            REQ:  m_req  = 1'b1;
            SEND: begin
                m_dvalid = 1'b1;
                m_data   = {8'h00, r_buf[r_rd_idx]};
                m_last   = (r_rd_idx == IDX_LAST);
            end
            default: ;
        endcase
    end

    assign m_addr     = r_addr;
    assign m_len      = 8'(BURST_LEN - 1);
    assign frame_done = r_frame_done;

    // Buffer contents need no reset: a reset forces a full refill before any read.
    always_ff @(posedge clkin) begin
        if (w_accept) r_buf[r_wr_idx] <= din;
    end

    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            r_wr_idx     <= '0;
            r_rd_idx     <= '0;
            r_pix_cnt    <= '0;
            r_addr       <= BASE_ADDR;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_accept) r_wr_idx <= r_wr_idx + 1'b1;
            if ((r_state == REQ) && m_gnt) r_rd_idx <= '0;
            else if (w_beat) r_rd_idx <= r_rd_idx + 1'b1;
            if (w_last_beat) begin
                if (w_pix_sum == PIX_FRAME) begin
                    r_pix_cnt    <= '0;
                    r_addr       <= BASE_ADDR;
                    r_frame_done <= 1'b1;
                end else begin
                    r_pix_cnt    <= w_pix_sum;
                    r_addr       <= r_addr + ADDR_STEP;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_burst_writer.sv
// Randomized self-checking bench for pixel_burst_writer using a burst-level
// reference model (pixel queue, frame pixel count, address from count).
module tb_pixel_burst_writer;

    localparam int unsigned BL   = 4;
    localparam int unsigned NPIX = 16;
    localparam logic [31:0] BASE = 32'h100;

    logic        clkin = 1'b0;
    logic        rst_n, en, value, m_gnt, m_dready;
    logic [23:0] din;
    logic        din_rd, m_req, m_dvalid, m_last, frame_done;
    logic [31:0] m_addr, m_data;
    logic [7:0]  m_len;

    int          checks = 0;
    int          failures = 0;
    int          m_pix = 0;
    bit          ramp = 1'b1;
    int          ramp_val = 1;
    logic [23:0] q[$];

    always #5 clkin = ~clkin;

    pixel_burst_writer #(.ROW(2), .COL(8), .BURST_LEN(BL), .ADDR_W(32), .BASE_ADDR(BASE)) dut (
        .clkin(clkin), .rst_n(rst_n), .en(en), .din(din), .din_rd(din_rd), .value(value),
        .m_req(m_req), .m_addr(m_addr), .m_len(m_len), .m_gnt(m_gnt), .m_data(m_data),
        .m_dvalid(m_dvalid), .m_dready(m_dready), .m_last(m_last), .frame_done(frame_done));

    task automatic step();
        @(posedge clkin);
        @(negedge clkin);
    endtask

    task automatic start_from_idle();
        checks++; if (din_rd !== 1'b0) begin failures++; $display("FAIL idle_din_rd got=%b exp=0", din_rd); end
        en = 1'b1;
        step();
        checks++; if (din_rd !== 1'b1) begin failures++; $display("FAIL first_din_rd got=%b exp=1", din_rd); end
    endtask

    // One burst from the first FILL cycle through the cycle after its last beat.
    // vmode: 0 value=1, 1 three idle cycles after 2nd accept, 2 random.
    // dmode: 0 ready=1, 1 pattern 1,0,0,1,1.., 2 random. rst_beat>=0 resets mid-SEND.
    task automatic do_burst(input int gnt_delay, input int vmode, input int dmode,
                            input bit en_next, input int rst_beat);
        int n = 0, c = 0, beats = 0, stall = 0;
        logic [31:0] ea;
        logic [23:0] expd;
        ea = BASE + 32'(4 * m_pix);
        m_gnt = (gnt_delay == 0);
        while (n < BL) begin
            if (c > 60) begin failures++; $display("FAIL fill_timeout accepts=%0d exp=%0d", n, BL); return; end
            checks++;
            if (din_rd !== 1'b1 || m_req !== 1'b0 || m_dvalid !== 1'b0) begin
                failures++; $display("FAIL fill_strobes din_rd=%b m_req=%b m_dvalid=%b exp=1,0,0", din_rd, m_req, m_dvalid);
            end
            if (c > 0) begin
                checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL fill_frame_done got=%b exp=0", frame_done); end
            end
            case (vmode)
                0: value = 1'b1;
                1: begin value = !(n == 2 && stall < 3); if (!value) stall++; end
                default: value = 1'($urandom_range(0, 1));
            endcase
            din = ramp ? 24'(ramp_val) : 24'($urandom);
            if (value) begin q.push_back(din); n++; if (ramp) ramp_val++; end
            step();
            c++;
        end
        value = 1'($urandom_range(0, 1));
        din = 24'($urandom);
        for (int d = 0; d <= gnt_delay; d++) begin
            checks++;
            if (m_req !== 1'b1 || m_addr !== ea || m_len !== 8'd3 || din_rd !== 1'b0 || m_dvalid !== 1'b0) begin
                failures++;
                $display("FAIL req_phase cyc=%0d m_req=%b m_addr=%h m_len=%0d din_rd=%b m_dvalid=%b exp=1,%h,3,0,0",
                         d, m_req, m_addr, m_len, din_rd, m_dvalid, ea);
            end
            m_gnt = (d == gnt_delay);
            step();
        end
        m_gnt = (gnt_delay == 0);
        en = en_next;
        c = 0;
        while (beats < BL) begin
            if (c > 60) begin failures++; $display("FAIL send_timeout beats=%0d exp=%0d", beats, BL); return; end
            expd = q[0];
            checks++;
            if (m_dvalid !== 1'b1 || m_req !== 1'b0 || din_rd !== 1'b0 || m_data !== {8'h00, expd} ||
                m_last !== (beats == BL - 1)) begin
                failures++;
                $display("FAIL send_beat beat=%0d m_dvalid=%b m_req=%b din_rd=%b m_data=%h m_last=%b exp=1,0,0,%h,%b",
                         beats, m_dvalid, m_req, din_rd, m_data, m_last, {8'h00, expd}, beats == BL - 1);
            end
            if (rst_beat >= 0 && beats == rst_beat) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
                q.delete();
                m_pix = 0;
                return;
            end
            case (dmode)
                0: m_dready = 1'b1;
                1: m_dready = !(c == 1 || c == 2);
                default: m_dready = 1'($urandom_range(0, 1));
            endcase
            if (m_dready) begin void'(q.pop_front()); beats++; end
            step();
            c++;
        end
        m_pix += BL;
        if (m_pix == NPIX) m_pix = 0;
        checks++;
        if (frame_done !== (m_pix == 0) || m_dvalid !== 1'b0 || m_last !== 1'b0 || din_rd !== en_next ||
            m_req !== 1'b0 || m_addr !== BASE + 32'(4 * m_pix)) begin
            failures++;
            $display("FAIL burst_end frame_done=%b m_dvalid=%b m_last=%b din_rd=%b m_req=%b m_addr=%h exp=%b,0,0,%b,0,%h",
                     frame_done, m_dvalid, m_last, din_rd, m_req, m_addr, m_pix == 0, en_next, BASE + 32'(4 * m_pix));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; value = 1'b0; m_gnt = 1'b0; m_dready = 1'b0; din = '0;
        step(); step();
        checks++;
        if (din_rd !== 1'b0 || m_req !== 1'b0 || m_dvalid !== 1'b0 || m_last !== 1'b0 || frame_done !== 1'b0 ||
            m_addr !== BASE || m_len !== 8'd3 || m_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_values din_rd=%b m_req=%b m_dvalid=%b m_last=%b frame_done=%b m_addr=%h m_len=%0d m_data=%h",
                     din_rd, m_req, m_dvalid, m_last, frame_done, m_addr, m_len, m_data);
        end
        rst_n = 1'b1;
        step();
        checks++; if (din_rd !== 1'b0) begin failures++; $display("FAIL idle_hold din_rd=%b exp=0", din_rd); end
        start_from_idle();
    endtask

    task automatic test_frame_ramp();
        for (int b = 0; b < 4; b++) do_burst(0, 0, 0, 1'b1, -1);
        ramp = 1'b0;
    endtask

    task automatic test_gnt_delay();
        do_burst(5, 0, 0, 1'b1, -1);
    endtask

    task automatic test_dready_stall();
        do_burst(0, 0, 1, 1'b1, -1);
    endtask

    task automatic test_value_stall();
        do_burst(0, 1, 0, 1'b1, -1);
    endtask

    task automatic test_en_drop();
        rst_n = 1'b0; en = 1'b0;
        step();
        rst_n = 1'b1; q.delete(); m_pix = 0;
        start_from_idle();
        do_burst(0, 2, 2, 1'b1, -1);
        do_burst(1, 2, 2, 1'b0, -1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (din_rd !== 1'b0 || m_req !== 1'b0 || m_dvalid !== 1'b0) begin
                failures++; $display("FAIL en_drop_idle din_rd=%b m_req=%b m_dvalid=%b exp=0,0,0", din_rd, m_req, m_dvalid);
            end
            step();
        end
        start_from_idle();
        checks++; if (m_addr !== 32'h120) begin failures++; $display("FAIL en_resume_addr got=%h exp=00000120", m_addr); end
        do_burst(0, 0, 0, 1'b1, -1);
    endtask

    task automatic test_reset_mid_burst();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; q.delete(); m_pix = 0;
        start_from_idle();
        do_burst(0, 2, 2, 1'b1, -1);
        do_burst(0, 2, 2, 1'b1, -1);
        do_burst(0, 2, 0, 1'b1, 2);
        checks++;
        if (din_rd !== 1'b0 || m_req !== 1'b0 || m_dvalid !== 1'b0 || m_last !== 1'b0 || frame_done !== 1'b0 ||
            m_addr !== BASE || m_data !== 32'h0) begin
            failures++;
            $display("FAIL midburst_reset din_rd=%b m_req=%b m_dvalid=%b m_last=%b frame_done=%b m_addr=%h m_data=%h",
                     din_rd, m_req, m_dvalid, m_last, frame_done, m_addr, m_data);
        end
        start_from_idle();
        do_burst(0, 0, 0, 1'b1, -1);
    endtask

    task automatic test_random();
        bit e;
        for (int b = 0; b < 12; b++) begin
            e = ($urandom_range(0, 3) != 0);
            do_burst(int'($urandom_range(0, 3)), 2, 2, e, -1);
            if (!e) begin
                step();
                start_from_idle();
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame_ramp();
        test_gnt_delay();
        test_dready_stall();
        test_value_stall();
        test_en_drop();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
